// File: rtl/inst_buffer_pkg.sv
// ---------------------------------------------------------------------------
// inst_buffer_pkg
// Shared definitions for the fetch-to-decode instruction buffer.
//   IBUF_DEPTH    default entry count of the buffer (power of 2, >= 8)
//   exception_t   fetch exception causes carried alongside an instruction
//   ibuf_entry_t  one buffered instruction with its pc, prediction and
//                 fetch-exception marker
//   make_entry    builds an entry from one fetch slot, applying the rule
//                 that an excepting slot carries no instruction/prediction
// ---------------------------------------------------------------------------
package inst_buffer_pkg;

    localparam int IBUF_DEPTH = 16;

    typedef enum logic [1:0] {
        ADEF = 2'd0,
        TLBR = 2'd1,
        PIF  = 2'd2,
        PPI  = 2'd3
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        exc;
        exception_t  exc_type;
    } ibuf_entry_t;

    // An excepting fetch has no usable instruction word, so the instruction
    // and prediction fields are zeroed to keep decode from acting on them.
    // Non-excepting entries park exc_type at ADEF; it is ignored when exc=0.
    function automatic ibuf_entry_t make_entry(
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        pred_taken,
        input logic [31:0] pred_target,
        input logic        exc,
        input exception_t  exc_type
    );
        ibuf_entry_t e;
        e.pc = pc;
        if (exc) begin
            e.inst        = 32'd0;
            e.pred_taken  = 1'b0;
            e.pred_target = 32'd0;
            e.exc         = 1'b1;
            e.exc_type    = exc_type;
        end else begin
            e.inst        = inst;
            e.pred_taken  = pred_taken;
            e.pred_target = pred_target;
            e.exc         = 1'b0;
            e.exc_type    = ADEF;
        end
        return e;
    endfunction

endpackage

// File: rtl/inst_buffer.sv
// ---------------------------------------------------------------------------
// inst_buffer
// Instruction queue between fetch and decode. Fetch pushes 0/1/2 entries per
// cycle, decode sees the two oldest entries and pops 0/1/2 per cycle. The
// queue is emptied on flush (branch mispredict or exception) and on reset.
//
// Ports
//   clk                     clock
//   reset                   synchronous, active-high reset
//   ibuf_input_size  [1:0]  entries pushed this cycle (0,1,2)
//   ibuf_ready              fetch may issue a new request
//   pc1/pc2         [31:0]  pc of push slot 1/2
//   inst1/inst2     [31:0]  instruction of push slot 1/2
//   pred_branch_taken1/2    predicted taken, slot 1/2
//   pred_branch_target1/2   predicted target, slot 1/2
//   have_exception          slot 1 carries a fetch exception
//   exception_type          fetch exception cause
//   flush                   pipeline redirect, empties the buffer
//   out_valid1/2            head / head+1 entry valid
//   out_entry1/2            head / head+1 entry contents
//   pop_size         [1:0]  entries consumed by decode this cycle
// ---------------------------------------------------------------------------
import inst_buffer_pkg::*;

module inst_buffer #(
    parameter int DEPTH = IBUF_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   ibuf_input_size,
    output logic         ibuf_ready,
    input  logic [31:0]  pc1,
    input  logic [31:0]  pc2,
    input  logic [31:0]  inst1,
    input  logic [31:0]  inst2,
    input  logic         pred_branch_taken1,
    input  logic         pred_branch_taken2,
    input  logic [31:0]  pred_branch_target1,
    input  logic [31:0]  pred_branch_target2,
    input  logic         have_exception,
    input  exception_t   exception_type,
    input  logic         flush,
    output logic         out_valid1,
    output logic         out_valid2,
    output ibuf_entry_t  out_entry1,
    output ibuf_entry_t  out_entry2,
    input  logic [1:0]   pop_size
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Ready threshold leaves room for one pair already returning from fetch
    // plus one pair from the request that ready is about to permit.
    localparam logic [CNT_W-1:0] READY_LIMIT = CNT_W'(DEPTH - 4);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_plus1;
    logic [PTR_W-1:0] wr_ptr_plus1;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    ibuf_entry_t mem [DEPTH];

    ibuf_entry_t entry_slot1;
    ibuf_entry_t entry_slot2;
    logic        clear;
    logic        push_en1;
    logic        push_en2;

    // Reset and flush both empty the queue; anything pushed or popped in
    // that same cycle is discarded, so they share one clear term.
    assign clear = reset | flush;

    // Pointers are exactly log2(DEPTH) bits, so the +1 neighbours wrap
    // around the ring naturally.
    assign rd_ptr_plus1 = rd_ptr + PTR_W'(1);
    assign wr_ptr_plus1 = wr_ptr + PTR_W'(1);

    // Build the two candidate entries from the fetch slots. Only slot 1 can
    // carry an exception; slot 2 is always an ordinary instruction.
    always_comb begin
        entry_slot1 = make_entry(pc1, inst1, pred_branch_taken1,
                                 pred_branch_target1, have_exception,
                                 exception_type);
        entry_slot2 = make_entry(pc2, inst2, pred_branch_taken2,
                                 pred_branch_target2, 1'b0, ADEF);
    end

    // Decode which write ports are active. Size 1 uses port 1 only, size 2
    // uses both; nothing is written while the queue is being cleared.
    always_comb begin
        push_en1 = 1'b0;
        push_en2 = 1'b0;
        if (!clear) begin
            push_en1 = (ibuf_input_size == 2'd1) || (ibuf_input_size == 2'd2);
            push_en2 = (ibuf_input_size == 2'd2);
        end
    end

    // Occupancy after this cycle's push and pop. Both may happen together;
    // a compliant producer/consumer never drives this outside 0..DEPTH.
    always_comb begin
        count_next = count
                   + {{(CNT_W-2){1'b0}}, ibuf_input_size}
                   - {{(CNT_W-2){1'b0}}, pop_size};
    end

    // Pointer and occupancy registers. The pointers simply advance by the
    // number of entries moved; clearing snaps everything back to zero so
    // the buffer restarts from a known slot after a redirect.
    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_size);
            wr_ptr <= wr_ptr + PTR_W'(ibuf_input_size);
            count  <= count_next;
        end
    end

    // Entry storage: two write ports into adjacent ring slots, which never
    // collide because they are always one apart. Storage is deliberately
    // not reset; validity comes solely from count.
    always_ff @(posedge clk) begin
        if (push_en1) begin
            mem[wr_ptr] <= entry_slot1;
        end
        if (push_en2) begin
            mem[wr_ptr_plus1] <= entry_slot2;
        end
    end

    // Decode view: the two oldest entries read straight from registered
    // state. A pushed entry therefore shows up one cycle later (no bypass).
    always_comb begin
        out_entry1 = mem[rd_ptr];
        out_entry2 = mem[rd_ptr_plus1];
        out_valid1 = (count >= CNT_W'(1));
        out_valid2 = (count >= CNT_W'(2));
    end

    // Fetch throttle. Held low while reset is asserted; during a flush it
    // still tracks the current count since fetch drops its own in-flight
    // data.
    always_comb begin
        ibuf_ready = !reset && (count <= READY_LIMIT);
    end

    // Protocol checks on the producer and consumer. None of these have a
    // recovery path; they flag a broken fetch or decode unit.
    a_no_size3: assert property (@(posedge clk) disable iff (reset || flush)
        ibuf_input_size != 2'd3);

    a_exc_single: assert property (@(posedge clk) disable iff (reset || flush)
        !(have_exception && (ibuf_input_size == 2'd2)));

    a_no_underflow: assert property (@(posedge clk) disable iff (reset || flush)
        int'(pop_size) <= int'(count));

    a_no_overflow: assert property (@(posedge clk) disable iff (reset || flush)
        (int'(count) + int'(ibuf_input_size) - int'(pop_size)) <= DEPTH);

endmodule
